vga_text_timing_gen: RTL and testbench

// Parametrised VGA raster timing generator with text-mode cell addressing.

---
 rtl/vga_text_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_vga_text_timing_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_timing_gen.sv
// VGA raster timing generator with text-mode cell addressing.
// Sync/blank are delayed PIPE_DLY pixel ticks to match the VRAM/font pipeline.
module vga_text_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CHAR_W   = 8,
  parameter int CHAR_H   = 16,
  parameter int PIPE_DLY = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        pix_ce,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [7:0]  char_col,
  output logic [6:0]  char_row,
  output logic [3:0]  glyph_x,
  output logic [4:0]  glyph_y,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        de,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] VA     = 11'(V_ACTIVE);
  localparam logic [10:0] HS_LO  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_HI  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_LO  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_HI  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  GX_LAST  = 4'(CHAR_W - 1);
  localparam logic [4:0]  GY_LAST  = 5'(CHAR_H - 1);
  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic        H_IDLE = (H_POL == 0);
  localparam logic        V_IDLE = (V_POL == 0);

  logic [3:0] div;
  logic       h_wrap;
  logic       v_last;
  logic       act;
  logic       hs;
  logic       vs;
  logic       ls_q;
  logic       fs_q;
  logic [2:0] dly [PIPE_DLY];

  assign pix_ce = !Rst && (div == DIV_LAST);
  assign h_wrap = (pix_x == H_LAST);
  assign v_last = (pix_y == V_LAST);

  assign act = (pix_x < HA) && (pix_y < VA);
  assign hs  = (pix_x >= HS_LO) && (pix_x < HS_HI);
  assign vs  = (pix_y >= VS_LO) && (pix_y < VS_HI);

  // Pixel-tick divider: wraps at CLK_DIV-1.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 4'd1;
    end
  end

  // Horizontal position and character column/glyph x.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pix_x    <= '0;
      char_col <= '0;
      glyph_x  <= '0;
    end else if (pix_ce) begin
      if (h_wrap) begin
        pix_x    <= '0;
        char_col <= '0;
        glyph_x  <= '0;
      end else begin
        pix_x <= pix_x + 11'd1;
        if (glyph_x == GX_LAST) begin
          glyph_x  <= '0;
          char_col <= char_col + 8'd1;
        end else begin
          glyph_x <= glyph_x + 4'd1;
        end
      end
    end
  end

  // Vertical position and character row/glyph y, stepped on line wrap.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pix_y    <= '0;
      char_row <= '0;
      glyph_y  <= '0;
    end else if (pix_ce && h_wrap) begin
      if (v_last) begin
        pix_y    <= '0;
        char_row <= '0;
        glyph_y  <= '0;
      end else begin
        pix_y <= pix_y + 11'd1;
        if (glyph_y == GY_LAST) begin
          glyph_y  <= '0;
          char_row <= char_row + 7'd1;
        end else begin
          glyph_y <= glyph_y + 5'd1;
        end
      end
    end
  end

  // Remember a wrap into column 0 so the start pulses skip the first tick.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else if (pix_ce) begin
      ls_q <= h_wrap;
      fs_q <= h_wrap && v_last;
    end
  end

  assign line_start  = pix_ce && ls_q;
  assign frame_start = pix_ce && fs_q;

  // Delay {act,hs,vs} to line up with the glyph pipeline.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < PIPE_DLY; i++) begin
        dly[i] <= '0;
      end
    end else if (pix_ce) begin
      dly[0] <= {act, hs, vs};
      for (int i = 1; i < PIPE_DLY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign blank_n = dly[PIPE_DLY-1][2];
  assign de      = dly[PIPE_DLY-1][2];
  assign hsync   = dly[PIPE_DLY-1][1] ^ H_IDLE;
  assign vsync   = dly[PIPE_DLY-1][0] ^ V_IDLE;

endmodule

// File: tb/tb_vga_text_timing_gen.sv
// Bench for vga_text_timing_gen: two scaled configurations
// checked cycle by cycle against an arithmetic raster model.
module tb_vga_text_timing_gen;

  localparam int A_DIV = 2;
  localparam int A_HA = 40, A_HF = 4, A_HS = 6, A_HB = 5;
  localparam int A_VA = 36, A_VF = 2, A_VS = 2, A_VB = 3;
  localparam int A_HP = 0, A_VP = 0, A_CW = 8, A_CH = 16, A_D = 2;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
  localparam int A_FR = A_HT * A_VT;

  localparam int B_DIV = 1;
  localparam int B_HA = 20, B_HF = 3, B_HS = 4, B_HB = 5;
  localparam int B_VA = 10, B_VF = 1, B_VS = 2, B_VB = 2;
  localparam int B_HP = 1, B_VP = 1, B_CW = 6, B_CH = 5, B_D = 5;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
  localparam int B_FR = B_HT * B_VT;

  logic Clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  logic        pce_a, hs_a, vs_a, bn_a, de_a, ls_a, fs_a;
  logic [10:0] px_a, py_a;
  logic [7:0]  cc_a;
  logic [6:0]  cr_a;
  logic [3:0]  gx_a;
  logic [4:0]  gy_a;

  logic        pce_b, hs_b, vs_b, bn_b, de_b, ls_b, fs_b;
  logic [10:0] px_b, py_b;
  logic [7:0]  cc_b;
  logic [6:0]  cr_b;
  logic [3:0]  gx_b;
  logic [4:0]  gy_b;

  logic [52:0] obs_a, obs_b;

  int checks = 0;
  int errors = 0;
  int ca = 0;
  int cb = 0;

  always #5 Clk = ~Clk;

  vga_text_timing_gen #(
    .CLK_DIV(A_DIV), .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS),
    .H_BP(A_HB), .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS),
    .V_BP(A_VB), .H_POL(A_HP), .V_POL(A_VP), .CHAR_W(A_CW),
    .CHAR_H(A_CH), .PIPE_DLY(A_D)
  ) dut_a (
    .Clk(Clk), .Rst(rst_a), .pix_ce(pce_a), .pix_x(px_a),
    .pix_y(py_a), .char_col(cc_a), .char_row(cr_a),
    .glyph_x(gx_a), .glyph_y(gy_a), .hsync(hs_a), .vsync(vs_a),
    .blank_n(bn_a), .de(de_a), .line_start(ls_a),
    .frame_start(fs_a)
  );

  vga_text_timing_gen #(
    .CLK_DIV(B_DIV), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS),
    .H_BP(B_HB), .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS),
    .V_BP(B_VB), .H_POL(B_HP), .V_POL(B_VP), .CHAR_W(B_CW),
    .CHAR_H(B_CH), .PIPE_DLY(B_D)
  ) dut_b (
    .Clk(Clk), .Rst(rst_b), .pix_ce(pce_b), .pix_x(px_b),
    .pix_y(py_b), .char_col(cc_b), .char_row(cr_b),
    .glyph_x(gx_b), .glyph_y(gy_b), .hsync(hs_b), .vsync(vs_b),
    .blank_n(bn_b), .de(de_b), .line_start(ls_b),
    .frame_start(fs_b)
  );

  assign obs_a = {pce_a, px_a, py_a, cc_a, cr_a, gx_a, gy_a,
                  hs_a, vs_a, bn_a, de_a, ls_a, fs_a};
  assign obs_b = {pce_b, px_b, py_b, cc_b, cr_b, gx_b, gy_b,
                  hs_b, vs_b, bn_b, de_b, ls_b, fs_b};

  // Expected outputs c Clk edges after reset release, from raster arithmetic.
  function automatic logic [52:0] model(
    int c, int dv, int ha, int hf, int hs, int hb,
    int va, int vf, int vs, int vb,
    int hp, int vp, int cw, int ch, int d);
    int ht, vt, n, x, y, m, xm, ym;
    logic ce, act, h, v, ls, fs, hpb, vpb;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    n = c / dv;
    ce = ((c % dv) == dv - 1);
    x = n % ht;
    y = (n / ht) % vt;
    act = 1'b0;
    h = 1'b0;
    v = 1'b0;
    if (n >= d) begin
      m = n - d;
      xm = m % ht;
      ym = (m / ht) % vt;
      act = (xm < ha) && (ym < va);
      h = (xm >= ha + hf) && (xm < ha + hf + hs);
      v = (ym >= va + vf) && (ym < va + vf + vs);
    end
    ls = ce && (n > 0) && (x == 0);
    fs = ls && (y == 0);
    hpb = (hp != 0);
    vpb = (vp != 0);
    return {ce, 11'(x), 11'(y), 8'(x / cw), 7'(y / ch),
            4'(x % cw), 5'(y % ch),
            h ? hpb : ~hpb, v ? vpb : ~vpb,
            act, act, ls, fs};
  endfunction

  function automatic logic [52:0] model_a(int c);
    return model(c, A_DIV, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF,
                 A_VS, A_VB, A_HP, A_VP, A_CW, A_CH, A_D);
  endfunction

  function automatic logic [52:0] model_b(int c);
    return model(c, B_DIV, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF,
                 B_VS, B_VB, B_HP, B_VP, B_CW, B_CH, B_D);
  endfunction

  task automatic test_reset();
    logic [52:0] ea, eb;
    repeat ($urandom_range(2, 6)) @(negedge Clk);
    #1;
    ea = model_a(0);
    ea[52] = 1'b0;
    eb = model_b(0);
    eb[52] = 1'b0;
    checks++;
    if (obs_a !== ea) begin
      errors++;
      $display("FAIL reset_a got=%h exp=%h", obs_a, ea);
    end
    checks++;
    if (obs_b !== eb) begin
      errors++;
      $display("FAIL reset_b got=%h exp=%h", obs_b, eb);
    end
  endtask

  task automatic test_frames_a();
    int total, extra, n, x, y;
    int n_ls, n_fs, n_bn, n_hs, n_vs;
    logic [52:0] e;
    total = 2 * A_FR * A_DIV;
    extra = $urandom_range(1, 40);
    n_ls = 0; n_fs = 0; n_bn = 0; n_hs = 0; n_vs = 0;
    @(negedge Clk);
    rst_a = 1'b0;
    for (int k = 0; k < total + extra; k++) begin
      if (k > 0) @(negedge Clk);
      #1;
      ca = k;
      e = model_a(k);
      checks++;
      if (obs_a !== e) begin
        errors++;
        $display("FAIL frame_a cyc=%0d got=%h exp=%h", k, obs_a, e);
      end
      n = k / A_DIV;
      x = n % A_HT;
      y = (n / A_HT) % A_VT;
      if (x == 17 && y == 35) begin
        checks++;
        if ({cc_a, gx_a, cr_a, gy_a} !== {8'd2, 4'd1, 7'd2, 5'd3}) begin
          errors++;
          $display("FAIL cell_17_35 got=%0d/%0d/%0d/%0d exp=2/1/2/3",
                   cc_a, gx_a, cr_a, gy_a);
        end
      end
      if (x == A_HT - 1) begin
        checks++;
        if ({cc_a, gx_a} !== {8'd6, 4'd6}) begin
          errors++;
          $display("FAIL cell_last got=%0d/%0d exp=6/6", cc_a, gx_a);
        end
      end
      if (k < total && pce_a) begin
        if (ls_a) n_ls++;
        if (fs_a) n_fs++;
        if (bn_a) n_bn++;
        if (hs_a == 1'(A_HP)) n_hs++;
        if (vs_a == 1'(A_VP)) n_vs++;
      end
    end
    checks++;
    if (n_ls != 2 * A_VT - 1) begin
      errors++;
      $display("FAIL line_pulses got=%0d exp=%0d", n_ls, 2 * A_VT - 1);
    end
    checks++;
    if (n_fs != 1) begin
      errors++;
      $display("FAIL frame_pulses got=%0d exp=1", n_fs);
    end
    checks++;
    if (n_bn != 2 * A_HA * A_VA) begin
      errors++;
      $display("FAIL blank_ticks got=%0d exp=%0d", n_bn, 2 * A_HA * A_VA);
    end
    checks++;
    if (n_hs != 2 * A_VT * A_HS) begin
      errors++;
      $display("FAIL hsync_ticks got=%0d exp=%0d", n_hs, 2 * A_VT * A_HS);
    end
    checks++;
    if (n_vs != 2 * A_VS * A_HT) begin
      errors++;
      $display("FAIL vsync_ticks got=%0d exp=%0d", n_vs, 2 * A_VS * A_HT);
    end
  endtask

  task automatic test_mid_reset();
    logic [52:0] e, er;
    er = model_a(0);
    er[52] = 1'b0;
    for (int it = 0; it < 3; it++) begin
      repeat ($urandom_range(50, 2500)) begin
        @(negedge Clk);
        #1;
        ca++;
        e = model_a(ca);
        checks++;
        if (obs_a !== e) begin
          errors++;
          $display("FAIL pre_rst_a cyc=%0d got=%h exp=%h", ca, obs_a, e);
        end
      end
      #2;
      rst_a = 1'b1;
      #1;
      checks++;
      if (obs_a !== er) begin
        errors++;
        $display("FAIL async_rst_a got=%h exp=%h", obs_a, er);
      end
      repeat ($urandom_range(1, 4)) @(negedge Clk);
      rst_a = 1'b0;
      ca = 0;
      for (int k = 0; k < (A_FR + 100) * A_DIV; k++) begin
        if (k > 0) @(negedge Clk);
        #1;
        ca = k;
        e = model_a(k);
        checks++;
        if (obs_a !== e) begin
          errors++;
          $display("FAIL post_rst_a cyc=%0d got=%h exp=%h", k, obs_a, e);
        end
      end
    end
  endtask

  task automatic test_div1_b();
    int k0, k1;
    logic [52:0] e;
    k0 = B_HA + B_HF;
    k1 = -1;
    @(negedge Clk);
    rst_b = 1'b0;
    for (int k = 0; k < 3 * B_FR; k++) begin
      if (k > 0) @(negedge Clk);
      #1;
      cb = k;
      e = model_b(k);
      checks++;
      if (obs_b !== e) begin
        errors++;
        $display("FAIL div1_b cyc=%0d got=%h exp=%h", k, obs_b, e);
      end
      if (k1 < 0 && hs_b === 1'b1) k1 = k;
    end
    checks++;
    if (k1 - k0 != B_D) begin
      errors++;
      $display("FAIL hsync_lag got=%0d exp=%0d", k1 - k0, B_D);
    end
  endtask

  task automatic test_back_to_back();
    logic [52:0] e, er;
    er = model_b(0);
    er[52] = 1'b0;
    for (int it = 0; it < 5; it++) begin
      repeat ($urandom_range(1, 600)) begin
        @(negedge Clk);
        #1;
        cb++;
        e = model_b(cb);
        checks++;
        if (obs_b !== e) begin
          errors++;
          $display("FAIL b2b_run cyc=%0d got=%h exp=%h", cb, obs_b, e);
        end
      end
      #($urandom_range(1, 3));
      rst_b = 1'b1;
      #1;
      checks++;
      if (obs_b !== er) begin
        errors++;
        $display("FAIL b2b_rst got=%h exp=%h", obs_b, er);
      end
      @(negedge Clk);
      rst_b = 1'b0;
      cb = 0;
      #1;
      e = model_b(0);
      checks++;
      if (obs_b !== e) begin
        errors++;
        $display("FAIL b2b_release got=%h exp=%h", obs_b, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames_a();
    test_mid_reset();
    test_div1_b();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
